// File: rtl/soc_bus_fabric_pkg.sv
// soc_bus_fabric_pkg: shared types and constants for the SoC bus fabric.
// Holds FSM encodings, status offsets and parameter defaults.
package soc_bus_fabric_pkg;

    localparam int unsigned IDX_W      = 4;
    localparam int unsigned MAX_SLAVES = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    localparam logic [4:0]  STAT_OFF_COUNT  = 5'h00;
    localparam logic [4:0]  STAT_OFF_FAULT  = 5'h04;
    localparam logic [31:0] ERR_RDATA_DEF   = 32'hBAD0_BAD0;
    localparam logic [15:0] STATUS_BASE_DEF = 16'h0047;

    // Slave 0 is program RAM; unused upper entries never win a match.
    localparam logic [16*MAX_SLAVES-1:0] BASE_TABLE_DEF = {
        {(MAX_SLAVES - 8){16'h0000}},
        16'h0046, 16'h0045, 16'h0044, 16'h0041,
        16'h0042, 16'h0043, 16'h0040, 16'h0000
    };

    typedef struct packed {
        logic [31:0]      addr;
        logic [31:0]      wdata;
        logic [3:0]       wmask;
        logic             is_write;
        logic             is_status;
        logic [IDX_W-1:0] idx;
    } req_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/soc_bus_fabric_if.sv
// soc_bus_fabric_if: CPU-side and peripheral-side bus bundles.
// The CPU masters the first, the fabric masters the second.
interface soc_cpu_bus_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rstrb;
    logic [31:0] mem_rdata;
    logic        mem_rbusy;
    logic        mem_wbusy;

    modport master (
        output mem_addr, mem_wdata, mem_wmask, mem_rstrb,
        input  mem_rdata, mem_rbusy, mem_wbusy
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_wmask, mem_rstrb,
        output mem_rdata, mem_rbusy, mem_wbusy
    );
endinterface

interface soc_periph_bus_if #(
    parameter int unsigned N = 8
);
    logic [N-1:0]    slv_cs;
    logic            slv_rd;
    logic            slv_wr;
    logic [4:0]      slv_addr;
    logic [31:0]     slv_wdata;
    logic [3:0]      slv_wmask;
    logic [32*N-1:0] slv_rdata;
    logic [N-1:0]    slv_ready;

    modport master (
        output slv_cs, slv_rd, slv_wr, slv_addr, slv_wdata, slv_wmask,
        input  slv_rdata, slv_ready
    );

    modport slave (
        input  slv_cs, slv_rd, slv_wr, slv_addr, slv_wdata, slv_wmask,
        output slv_rdata, slv_ready
    );
endinterface

// File: rtl/soc_bus_fabric_addr_decoder.sv
// soc_addr_decoder: maps addr[31:16] to a slave select.
// Reports raw table hits; the caller resolves the default slave.
module soc_addr_decoder
    import soc_bus_fabric_pkg::*;
#(
    parameter int unsigned              NUM_SLAVES  = 8,
    parameter logic [16*NUM_SLAVES-1:0] BASE_TABLE  =
        BASE_TABLE_DEF[16*NUM_SLAVES-1:0],
    parameter logic [15:0]              STATUS_BASE = STATUS_BASE_DEF
) (
    input  logic [15:0]           addr_hi,
    output logic [NUM_SLAVES-1:0] hit_sel,
    output logic [IDX_W-1:0]      hit_idx,
    output logic                  is_status,
    output logic                  is_default
);

    logic found;

    // Lowest-indexed matching table entry wins; status base shadows the table.
    always_comb begin
        hit_sel   = '0;
        hit_idx   = '0;
        found     = 1'b0;
        is_status = (addr_hi == STATUS_BASE);
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (!found && !is_status &&
                addr_hi == BASE_TABLE[16*i +: 16]) begin
                found      = 1'b1;
                hit_sel[i] = 1'b1;
                hit_idx    = IDX_W'(i);
            end
        end
        is_default = !found && !is_status;
    end

endmodule

// File: rtl/soc_bus_fabric.sv
// soc_bus_fabric: FemtoRV32 CPU-to-peripheral fabric.
// One outstanding access, registered request, timeout with status slave.
module soc_bus_fabric
    import soc_bus_fabric_pkg::*;
#(
    parameter int unsigned              NUM_SLAVES    = 8,
    parameter logic [16*NUM_SLAVES-1:0] BASE_TABLE    =
        BASE_TABLE_DEF[16*NUM_SLAVES-1:0],
    parameter int unsigned              DEFAULT_SLAVE = 0,
    parameter logic [15:0]              STATUS_BASE   = STATUS_BASE_DEF,
    parameter int unsigned              TIMEOUT       = 255,
    parameter logic [31:0]              ERR_RDATA     = ERR_RDATA_DEF
) (
    input  logic             clk,
    input  logic             reset,
    soc_cpu_bus_if.slave     cpu,
    soc_periph_bus_if.master periph,
    output logic             err_irq
);

    localparam logic [NUM_SLAVES-1:0] DEF_SEL =
        NUM_SLAVES'(1) << DEFAULT_SLAVE;
    localparam logic [IDX_W-1:0] DEF_IDX  = IDX_W'(DEFAULT_SLAVE);
    localparam logic [15:0]      CNT_LAST = 16'(TIMEOUT - 1);

    state_t                state_q, state_d;
    req_t                  req_q, req_d;
    logic [NUM_SLAVES-1:0] cs_q, cs_d;
    logic                  seen_q, seen_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [7:0]            err_count_q, err_count_d;
    logic [31:0]           fault_addr_q, fault_addr_d;

    logic [NUM_SLAVES-1:0] dec_sel;
    logic [IDX_W-1:0]      dec_idx;
    logic                  dec_is_status;
    logic                  dec_is_default;

    logic        wr_strobe;
    logic        rd_strobe;
    logic        in_flight;
    logic        sel_ready;
    logic [31:0] sel_rdata;
    logic [31:0] stat_rdata;

    soc_addr_decoder #(
        .NUM_SLAVES  (NUM_SLAVES),
        .BASE_TABLE  (BASE_TABLE),
        .STATUS_BASE (STATUS_BASE)
    ) u_dec (
        .addr_hi    (cpu.mem_addr[31:16]),
        .hit_sel    (dec_sel),
        .hit_idx    (dec_idx),
        .is_status  (dec_is_status),
        .is_default (dec_is_default)
    );

    // A write mask wins over a simultaneous read strobe.
    assign wr_strobe = |cpu.mem_wmask;
    assign rd_strobe = cpu.mem_rstrb && !wr_strobe;
    assign in_flight = (state_q == ST_REQ) || (state_q == ST_WAIT);
    assign sel_ready = |(periph.slv_ready & cs_q);

    assign cpu.mem_rdata = rdata_q;
    assign cpu.mem_wbusy = (state_q == ST_IDLE && wr_strobe) ||
                           (in_flight && req_q.is_write);
    assign cpu.mem_rbusy = (state_q == ST_IDLE && rd_strobe) ||
                           (in_flight && !req_q.is_write);

    assign periph.slv_cs    = cs_q;
    assign periph.slv_rd    = (state_q == ST_REQ) &&
                              !req_q.is_write && !req_q.is_status;
    assign periph.slv_wr    = (state_q == ST_REQ) &&
                              req_q.is_write && !req_q.is_status;
    assign periph.slv_addr  = req_q.addr[4:0];
    assign periph.slv_wdata = req_q.wdata;
    assign periph.slv_wmask = req_q.wmask;

    assign err_irq = (state_q == ST_ERR);

    // Read data mux for the latched slave index.
    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (req_q.idx == IDX_W'(i)) begin
                sel_rdata = periph.slv_rdata[32*i +: 32];
            end
        end
    end

    // Built-in status slave register map.
    always_comb begin
        stat_rdata = '0;
        unique case (1'b1)
            (req_q.addr[4:0] == STAT_OFF_COUNT):
                stat_rdata = {24'h0, err_count_q};
            (req_q.addr[4:0] == STAT_OFF_FAULT):
                stat_rdata = fault_addr_q;
            default:
                stat_rdata = '0;
        endcase
    end

    // Transaction FSM: next state, request latch, capture and fault log.
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        cs_d         = cs_q;
        seen_d       = seen_q;
        cnt_d        = cnt_q;
        rdata_d      = rdata_q;
        err_count_d  = err_count_q;
        fault_addr_d = fault_addr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cpu.mem_rstrb || wr_strobe) begin
                    req_d.addr      = cpu.mem_addr;
                    req_d.wdata     = cpu.mem_wdata;
                    req_d.wmask     = cpu.mem_wmask;
                    req_d.is_write  = wr_strobe;
                    req_d.is_status = dec_is_status;
                    req_d.idx       = dec_is_default ? DEF_IDX : dec_idx;
                    cs_d            = dec_is_status  ? '0 :
                                      dec_is_default ? DEF_SEL : dec_sel;
                    state_d         = ST_REQ;
                end
            end
            ST_REQ: begin
                cnt_d  = '0;
                seen_d = 1'b0;
                if (req_q.is_status) begin
                    seen_d = 1'b1;
                    if (req_q.is_write) begin
                        err_count_d  = '0;
                        fault_addr_d = '0;
                    end else begin
                        rdata_d = stat_rdata;
                    end
                end else if (sel_ready) begin
                    seen_d = 1'b1;
                    if (!req_q.is_write) begin
                        rdata_d = sel_rdata;
                    end
                end
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (seen_q) begin
                    cs_d    = '0;
                    state_d = ST_DONE;
                end else if (sel_ready) begin
                    if (!req_q.is_write) begin
                        rdata_d = sel_rdata;
                    end
                    cs_d    = '0;
                    state_d = ST_DONE;
                end else if (cnt_q >= CNT_LAST) begin
                    if (!req_q.is_write) begin
                        rdata_d = ERR_RDATA;
                    end
                    cs_d    = '0;
                    state_d = ST_ERR;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                err_count_d  = sat_inc8(err_count_q);
                fault_addr_d = req_q.addr;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            req_q        <= '0;
            cs_q         <= '0;
            seen_q       <= 1'b0;
            cnt_q        <= '0;
            rdata_q      <= '0;
            err_count_q  <= '0;
            fault_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            cs_q         <= cs_d;
            seen_q       <= seen_d;
            cnt_q        <= cnt_d;
            rdata_q      <= rdata_d;
            err_count_q  <= err_count_d;
            fault_addr_q <= fault_addr_d;
        end
    end

endmodule
